pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register, successor to the fixed-field ID/EX latch.

---
 rtl/pipe_stage_skid.sv | 167 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer.
// Handshake is valid/ready; in_ready is a flop (skid slot empty), so there is
// no combinational path from in_valid or out_ready to in_ready. Any flush
// request kills every held beat. A saturating counter records killed beats.
`timescale 1ns/1ps

module pipe_stage_skid #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter int N_FLUSH    = 4,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic [N_FLUSH-1:0] flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  kill_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CTRL_W-1:0]   head_ctrl_r, head_ctrl_nxt_s;
  logic [DATA_W-1:0]   head_data_r, head_data_nxt_s;
  logic [CTRL_W-1:0]   skid_ctrl_r, skid_ctrl_nxt_s;
  logic [DATA_W-1:0]   skid_data_r, skid_data_nxt_s;
  logic                in_ready_r, out_valid_r;
  logic [1:0]          occ_r;
  logic [CNT_W-1:0]    kill_cnt_r, kill_cnt_nxt_s;
  logic                acc_s, pop_s, flush_s;
  logic [1:0]          held_s, kill_inc_s;
  logic [CNT_W:0]      kill_sum_s;

  // Number of beats held in a given state.
  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_EMPTY: occ_of = 2'd0;
      ST_ONE:   occ_of = 2'd1;
      ST_FULL:  occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

  // Next-state, datapath and kill-count logic; flush overrides every transition.
  always_comb begin
    acc_s           = in_valid & in_ready_r;
    pop_s           = out_valid_r & out_ready;
    flush_s         = |flush_i;
    state_nxt_s     = state_r;
    head_ctrl_nxt_s = head_ctrl_r;
    head_data_nxt_s = head_data_r;
    skid_ctrl_nxt_s = skid_ctrl_r;
    skid_data_nxt_s = skid_data_r;
    held_s          = occ_of(state_r);
    kill_inc_s      = 2'd0;
    if (flush_s) begin
      // A pop in the flush cycle still completes downstream, so it is not a kill.
      kill_inc_s      = held_s - {1'b0, pop_s};
      state_nxt_s     = ST_EMPTY;
      head_ctrl_nxt_s = '0;
      skid_ctrl_nxt_s = '0;
      if (CLEAR_DATA) begin
        head_data_nxt_s = '0;
        skid_data_nxt_s = '0;
      end else begin
        head_data_nxt_s = head_data_r;
        skid_data_nxt_s = skid_data_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            head_ctrl_nxt_s = in_ctrl;
            head_data_nxt_s = in_data;
            state_nxt_s     = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            head_ctrl_nxt_s = in_ctrl;
            head_data_nxt_s = in_data;
          end else if (acc_s) begin
            skid_ctrl_nxt_s = in_ctrl;
            skid_data_nxt_s = in_data;
            state_nxt_s     = ST_FULL;
          end else if (pop_s) begin
            // Keep head ctrl zero while empty so out_ctrl never leaks stale controls.
            head_ctrl_nxt_s = '0;
            state_nxt_s     = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            head_ctrl_nxt_s = skid_ctrl_r;
            head_data_nxt_s = skid_data_r;
            skid_ctrl_nxt_s = '0;
            skid_data_nxt_s = '0;
            state_nxt_s     = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s     = ST_EMPTY;
          head_ctrl_nxt_s = '0;
          skid_ctrl_nxt_s = '0;
        end
      endcase
    end
    kill_sum_s = {1'b0, kill_cnt_r} + (CNT_W + 1)'(kill_inc_s);
    if (kill_sum_s[CNT_W]) begin
      kill_cnt_nxt_s = '1;
    end else begin
      kill_cnt_nxt_s = kill_sum_s[CNT_W-1:0];
    end
  end

  // State, payload and status registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_ctrl_r <= '0;
      head_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
      kill_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      head_ctrl_r <= head_ctrl_nxt_s;
      head_data_r <= head_data_nxt_s;
      skid_ctrl_r <= skid_ctrl_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occ_r       <= occ_of(state_nxt_s);
      kill_cnt_r  <= kill_cnt_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_ctrl   = head_ctrl_r;
  assign out_data   = head_data_r;
  assign occ_o      = occ_r;
  assign kill_cnt_o = kill_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: default-parameter instance driven
// through a queue/monitor pair, plus a CLEAR_DATA=0 / CNT_W=2 instance for
// data retention, counter saturation and asynchronous reset.
`timescale 1ns/1ps

module tb_pipe_stage_skid;
  localparam int CW = 16;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [3:0]    flush_i;
  logic [1:0]    occ_o;
  logic [15:0]   kill_cnt_o;

  logic          b_rst_n;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]    b_in_ctrl, b_out_ctrl;
  logic [31:0]   b_in_data, b_out_data;
  logic [3:0]    b_flush;
  logic [1:0]    b_occ;
  logic [1:0]    b_kill;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush_i(flush_i), .occ_o(occ_o), .kill_cnt_o(kill_cnt_o)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .N_FLUSH(4), .CLEAR_DATA(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .flush_i(b_flush), .occ_o(b_occ), .kill_cnt_o(b_kill)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_vec = 0;
  int    n_miss = 0;
  logic  mon_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every beat leaving the stage must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_ctrl, out_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_beat", {out_ctrl, out_data}, {mon_e.c, mon_e.d});
        end
      end
      if (!out_valid) chk("ctrl_zero_idle", 160'(out_ctrl), 160'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    int t = 0;
    bit done = 1'b0;
    while (!done && t < 30) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: got no accept expected accept within 30 cycles", name);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    exp_q.push_back({c, d});
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    wait_accept("send_timeout");
  endtask

  task automatic drain();
    int t = 0;
    while (occ_o != 2'd0 && t < 30) begin
      tick();
      t++;
    end
    chk("drain_empty", 160'(occ_o), 160'd0);
  endtask

  task automatic b_send(input logic [7:0] c, input logic [31:0] d);
    b_in_valid = 1'b1;
    b_in_ctrl  = c;
    b_in_data  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush_i = 4'b0000;
    b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 4'b0000;
    rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'd0);
    chk("rst_in_ready", 160'(in_ready), 160'd1);
    chk("rst_occ", 160'(occ_o), 160'd0);
    chk("rst_kill", 160'(kill_cnt_o), 160'd0);
    chk("rst_out_ctrl", 160'(out_ctrl), 160'd0);
    chk("rst_out_data", 160'(out_data), 160'd0);
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Streaming: one beat per cycle, occupancy steady at 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 128'(i));
      chk("stream_valid", 160'(out_valid), 160'd1);
      chk("stream_occ", 160'(occ_o), 160'd1);
      chk("stream_in_ready", 160'(in_ready), 160'd1);
    end
    drain();

    // Backpressure: A,B fill the stage, C is held off until the head drains.
    out_ready = 1'b0;
    send(16'h00A1, 128'hA1A1);
    send(16'h00B2, 128'hB2B2);
    chk("bp_occ_full", 160'(occ_o), 160'd2);
    chk("bp_in_ready_low", 160'(in_ready), 160'd0);
    exp_q.push_back({16'h00C3, 128'hC3C3});
    in_valid = 1'b1;
    in_ctrl  = 16'h00C3;
    in_data  = 128'hC3C3;
    tick();
    tick();
    chk("bp_hold_occ", 160'(occ_o), 160'd2);
    chk("bp_hold_in_ready", 160'(in_ready), 160'd0);
    out_ready = 1'b1;
    wait_accept("bp_c_timeout");
    drain();
    chk("bp_all_out", 160'(exp_q.size()), 160'd0);

    // Flush while FULL with C offered: both held beats killed, C discarded.
    out_ready = 1'b0;
    send(16'h0A0A, 128'h1111);
    send(16'h0B0B, 128'h2222);
    in_valid = 1'b1;
    in_ctrl  = 16'h0C0C;
    in_data  = 128'h3333;
    flush_i  = 4'b0100;
    tick();
    flush_i  = 4'b0000;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_occ", 160'(occ_o), 160'd0);
    chk("flush_out_valid", 160'(out_valid), 160'd0);
    chk("flush_out_ctrl", 160'(out_ctrl), 160'd0);
    chk("flush_out_data", 160'(out_data), 160'd0);
    chk("flush_kill2", 160'(kill_cnt_o), 160'd2);
    chk("flush_in_ready", 160'(in_ready), 160'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_c", 160'(out_valid), 160'd0);

    // Flush in ONE with a beat offered while in_ready is high.
    out_ready = 1'b0;
    send(16'h0D0D, 128'h4444);
    in_valid = 1'b1;
    in_ctrl  = 16'h0E0E;
    in_data  = 128'h5555;
    flush_i  = 4'b1000;
    tick();
    flush_i  = 4'b0000;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_one_occ", 160'(occ_o), 160'd0);
    chk("flush_one_kill3", 160'(kill_cnt_o), 160'd3);

    // Flush coinciding with a pop: head is consumed, not counted as killed.
    send(16'h0F0F, 128'h6666);
    out_ready = 1'b1;
    flush_i   = 4'b0011;
    tick();
    flush_i   = 4'b0000;
    chk("flushpop_consumed", 160'(exp_q.size()), 160'd0);
    chk("flushpop_kill", 160'(kill_cnt_o), 160'd3);
    chk("flushpop_occ", 160'(occ_o), 160'd0);

    // Flush while empty is a no-op.
    flush_i = 4'b1111;
    tick();
    flush_i = 4'b0000;
    chk("flush_empty_kill", 160'(kill_cnt_o), 160'd3);

    // Stage still works after flushes.
    send(16'h1234, 128'h0123_4567_89AB_CDEF);
    drain();

    // CLEAR_DATA=0: flush clears valid/ctrl but keeps data.
    b_send(8'h5A, 32'hDEADBEEF);
    chk("b_head_data", 160'(b_out_data), 160'hDEADBEEF);
    b_flush = 4'b0001;
    tick();
    b_flush = 4'b0000;
    chk("b_keep_valid", 160'(b_out_valid), 160'd0);
    chk("b_keep_ctrl", 160'(b_out_ctrl), 160'd0);
    chk("b_keep_data", 160'(b_out_data), 160'hDEADBEEF);
    chk("b_kill1", 160'(b_kill), 160'd1);

    // Saturation with a 2-bit counter: 1 + 2 + 1 kills stays at 3.
    b_send(8'h01, 32'h1);
    b_send(8'h02, 32'h2);
    chk("b_full", 160'(b_occ), 160'd2);
    b_flush = 4'b0010;
    tick();
    b_flush = 4'b0000;
    chk("b_kill3", 160'(b_kill), 160'd3);
    b_send(8'h03, 32'h3);
    b_flush = 4'b0100;
    tick();
    b_flush = 4'b0000;
    chk("b_kill_sat", 160'(b_kill), 160'd3);

    // Asynchronous reset between clock edges with a beat held.
    b_send(8'h77, 32'h12345678);
    chk("b_pre_rst_valid", 160'(b_out_valid), 160'd1);
    @(negedge clk);
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("b_arst_valid", 160'(b_out_valid), 160'd0);
    chk("b_arst_ctrl", 160'(b_out_ctrl), 160'd0);
    chk("b_arst_data", 160'(b_out_data), 160'd0);
    chk("b_arst_occ", 160'(b_occ), 160'd0);
    chk("b_arst_kill", 160'(b_kill), 160'd0);
    chk("b_arst_in_ready", 160'(b_in_ready), 160'd1);
    tick();
    b_rst_n = 1'b1;
    tick();

    chk("final_queue_empty", 160'(exp_q.size()), 160'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
